mux_nx1_arb: RTL and testbench

MUX_NX1_ARB -- requirements
Module: mux_nx1_arb

---
 rtl/mux_nx1_arb_pkg.sv | 11 +
 rtl/mux_nx1_arb_if.sv | 24 ++
 rtl/mux_nx1_arb_arbiter.sv | 58 +++++
 rtl/mux_nx1_arb.sv | 87 ++++++++
 tb/tb_mux_nx1_arb.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mux_nx1_arb_pkg.sv
// Shared definitions for the N:1 arbitrated mux: the arbitration mode encodings.
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_RR    = 2'b01,
        MODE_FORCE = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

endpackage

// File: rtl/mux_nx1_arb_if.sv
// Channel-side and output-side handshake bundle of the N:1 arbitrated mux.
interface mux_nx1_arb_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_chan;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/mux_nx1_arb_arbiter.sv
// Stateless grant logic: fixed priority, round-robin from ptr, forced select, or hold.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  mode_e           mode,
    input  logic [SELW-1:0] sel,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    logic        hit;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        hit       = 1'b0;
        idx       = 0;
        case (mode)
            MODE_FIXED: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!hit && req[i]) begin
                        grant[i]  = 1'b1;
                        grant_idx = SELW'(i);
                        hit       = 1'b1;
                    end
                end
            end
            MODE_RR: begin
                // Scan N slots starting at ptr, folding the index back into 0..N-1.
                for (int unsigned i = 0; i < N; i++) begin
                    idx = 32'(ptr) + i;
                    if (idx >= N) idx = idx - N;
                    if (!hit && req[idx]) begin
                        grant[idx] = 1'b1;
                        grant_idx  = SELW'(idx);
                        hit        = 1'b1;
                    end
                end
            end
            MODE_FORCE: begin
                if (32'(sel) < N) begin
                    if (req[sel]) begin
                        grant[sel] = 1'b1;
                        grant_idx  = sel;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mux_nx1_arb.sv
// N:1 valid/ready mux with selectable arbitration and a single registered output stage.
module mux_nx1_arb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mode,
    input  logic [SELW-1:0] sel,
    mux_nx1_arb_if.slave    bus
);

    mode_e            mode_s;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] grant_word;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    assign mode_s = mode_e'(mode);

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req       (bus.in_valid),
        .ptr       (rr_ptr_q),
        .mode      (mode_s),
        .sel       (sel),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign can_accept   = !out_valid_q || bus.out_ready;
    // rst_n gates ready so nothing is offered while reset is held.
    assign bus.in_ready = (rst_n && can_accept) ? grant : '0;
    assign xfer         = |bus.in_ready;

    always_comb begin
        grant_word = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant[k]) grant_word = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_word;
            out_chan_d  = grant_idx;
            rr_ptr_d    = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Directed-vector bench for mux_nx1_arb (N=4, WIDTH=8, SELW=3 so out-of-range sel is reachable).
module tb_mux_nx1_arb;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned SELW  = 3;
    localparam int unsigned NVEC  = 25;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  sel;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [2:0]  exp_oc;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      mode;
    logic [SELW-1:0] sel;
    int              checks;
    int              errors;
    vec_t            vecs [NVEC];

    mux_nx1_arb_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

    mux_nx1_arb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [2:0] s, input logic [3:0] v,
                                input logic r, input logic [3:0] er, input logic eov,
                                input logic [7:0] eod, input logic [2:0] eoc);
        vec_t t;
        t.mode = m; t.sel = s; t.valid = v; t.ordy = r;
        t.exp_ready = er; t.exp_ov = eov; t.exp_od = eod; t.exp_oc = eoc;
        return t;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 4; k++) bus.in_data[k*8 +: 8] = 8'hA0 + 8'(k);

        vecs[0]  = mk(2'd0, 3'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 3'd0);
        vecs[1]  = mk(2'd2, 3'd3, 4'hF, 1'b1, 4'h8, 1'b1, 8'hA3, 3'd3);
        vecs[2]  = mk(2'd1, 3'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 3'd0);
        vecs[3]  = mk(2'd1, 3'd0, 4'hF, 1'b1, 4'h2, 1'b1, 8'hA1, 3'd1);
        vecs[4]  = mk(2'd1, 3'd0, 4'hF, 1'b1, 4'h4, 1'b1, 8'hA2, 3'd2);
        vecs[5]  = mk(2'd1, 3'd0, 4'hF, 1'b1, 4'h8, 1'b1, 8'hA3, 3'd3);
        vecs[6]  = mk(2'd1, 3'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 3'd0);
        vecs[7]  = mk(2'd1, 3'd0, 4'hF, 1'b0, 4'h0, 1'b1, 8'hA0, 3'd0);
        vecs[8]  = mk(2'd1, 3'd0, 4'hF, 1'b0, 4'h0, 1'b1, 8'hA0, 3'd0);
        vecs[9]  = mk(2'd1, 3'd0, 4'hF, 1'b0, 4'h0, 1'b1, 8'hA0, 3'd0);
        vecs[10] = mk(2'd1, 3'd0, 4'hF, 1'b1, 4'h2, 1'b1, 8'hA1, 3'd1);
        vecs[11] = mk(2'd3, 3'd0, 4'hF, 1'b1, 4'h0, 1'b0, 8'hA1, 3'd1);
        vecs[12] = mk(2'd3, 3'd0, 4'hF, 1'b1, 4'h0, 1'b0, 8'hA1, 3'd1);
        vecs[13] = mk(2'd2, 3'd2, 4'hF, 1'b1, 4'h4, 1'b1, 8'hA2, 3'd2);
        vecs[14] = mk(2'd2, 3'd2, 4'hF, 1'b1, 4'h4, 1'b1, 8'hA2, 3'd2);
        vecs[15] = mk(2'd2, 3'd5, 4'hF, 1'b1, 4'h0, 1'b0, 8'hA2, 3'd2);
        vecs[16] = mk(2'd2, 3'd4, 4'hF, 1'b1, 4'h0, 1'b0, 8'hA2, 3'd2);
        vecs[17] = mk(2'd2, 3'd2, 4'hB, 1'b1, 4'h0, 1'b0, 8'hA2, 3'd2);
        vecs[18] = mk(2'd0, 3'd0, 4'h6, 1'b1, 4'h2, 1'b1, 8'hA1, 3'd1);
        vecs[19] = mk(2'd0, 3'd0, 4'h6, 1'b1, 4'h2, 1'b1, 8'hA1, 3'd1);
        vecs[20] = mk(2'd1, 3'd0, 4'h6, 1'b1, 4'h4, 1'b1, 8'hA2, 3'd2);
        vecs[21] = mk(2'd1, 3'd0, 4'h9, 1'b1, 4'h8, 1'b1, 8'hA3, 3'd3);
        vecs[22] = mk(2'd1, 3'd0, 4'h9, 1'b1, 4'h1, 1'b1, 8'hA0, 3'd0);
        vecs[23] = mk(2'd1, 3'd0, 4'h0, 1'b0, 4'h0, 1'b1, 8'hA0, 3'd0);
        vecs[24] = mk(2'd1, 3'd0, 4'h0, 1'b1, 4'h0, 1'b0, 8'hA0, 3'd0);

        rst_n         = 1'b0;
        mode          = 2'd0;
        sel           = '0;
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  32'(bus.in_ready),  32'h0);
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_out_data",  32'(bus.out_data),  32'h0);
        check("reset_out_chan",  32'(bus.out_chan),  32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            mode          = vecs[i].mode;
            sel           = vecs[i].sel;
            bus.in_valid  = vecs[i].valid;
            bus.out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d_out_data", i),  32'(bus.out_data),  32'(vecs[i].exp_od));
            check($sformatf("v%0d_out_chan", i),  32'(bus.out_chan),  32'(vecs[i].exp_oc));
        end

        // Load a word that stalls (rr_ptr becomes 1), then reset between edges.
        mode          = 2'd0;
        bus.in_valid  = 4'h1;
        bus.out_ready = 1'b0;
        #1;
        check("ar_load_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("ar_load_valid", 32'(bus.out_valid), 32'h1);
        check("ar_load_data",  32'(bus.out_data),  32'hA0);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_mid_valid", 32'(bus.out_valid), 32'h0);
        check("ar_mid_data",  32'(bus.out_data),  32'h0);
        check("ar_mid_ready", 32'(bus.in_ready),  32'h0);
        @(posedge clk);
        #1;
        check("ar_held_valid", 32'(bus.out_valid), 32'h0);
        bus.in_valid  = 4'h0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        @(posedge clk);
        #1;
        check("ar_release_valid", 32'(bus.out_valid), 32'h0);

        // rr_ptr must be back at 0: round-robin with all valid grants ch0.
        mode         = 2'd1;
        bus.in_valid = 4'hF;
        #1;
        check("ar_rr_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("ar_rr_valid", 32'(bus.out_valid), 32'h1);
        check("ar_rr_data",  32'(bus.out_data),  32'hA0);
        check("ar_rr_chan",  32'(bus.out_chan),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
